mem_fill_responder: RTL and testbench

MEM_FILL_RESPONDER -- requirements
Module: mem_fill_responder

---
 rtl/mem_fill_responder.sv | 110 +++++++++++
 tb/tb_mem_fill_responder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_fill_responder.sv
// mem_fill_responder: fixed-latency word-write / 8-word block-read responder over a 16-bit word array
module mem_fill_responder #(
    parameter int LATENCY = 4,
    parameter int ADDR_W  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_data,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [15:0] resp_data,
    output logic [2:0]  resp_word,
    output logic        wr_done,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_BURST, WR_WAIT} state_t;

    localparam int         DEPTH  = 1 << ADDR_W;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-4:0]   blk_q, blk_d;
    logic [2:0]          word_q, word_d;
    logic [15:0]         data_q, data_d;
    logic                ready_q, valid_q, done_q, done_d, busy_q;
    logic [ADDR_W-1:0]   widx;
    logic                accept;
    logic                unused_addr;
    logic [15:0]         mem [0:DEPTH-1] = '{default: 16'h0000};

    assign widx        = req_addr[ADDR_W:1];
    assign unused_addr = ^{req_addr[15:ADDR_W+1], req_addr[0]};
    assign accept      = req_valid && ready_q && !rst;

    assign req_ready  = ready_q;
    assign resp_valid = valid_q;
    assign resp_data  = data_q;
    assign resp_word  = word_q;
    assign wr_done    = done_q;
    assign busy       = busy_q;

    // Writes commit on the accepting edge so any later read of the block sees them.
    always_ff @(posedge clk) begin
        if (accept && req_wr) mem[widx] <= req_data;
    end

    // Next-state: latency countdown, then either an 8-beat burst or a one-cycle write completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blk_d   = blk_q;
        word_d  = 3'd0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                state_d = req_wr ? WR_WAIT : RD_WAIT;
                cnt_d   = LAT_M1;
                blk_d   = req_wr ? blk_q : widx[ADDR_W-1:3];
            end
            RD_WAIT: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = cnt_q == 4'd1 ? RD_BURST : RD_WAIT;
            end
            RD_BURST: begin
                word_d  = word_q + 3'd1;
                state_d = word_q == 3'd7 ? IDLE : RD_BURST;
            end
            WR_WAIT: begin
                cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
                done_d  = cnt_q == 4'd1;
                state_d = cnt_q == 4'd0 ? IDLE : WR_WAIT;
            end
            default: state_d = IDLE;
        endcase
    end

    // Beat data is looked up from the next-cycle block and word so it lands registered with resp_valid.
    always_comb begin
        data_d = state_d == RD_BURST ? mem[{blk_d, word_d}] : 16'h0000;
    end

    // State and registered outputs; reset aborts any operation but leaves the array intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            blk_q   <= '0;
            word_q  <= 3'd0;
            data_q  <= 16'h0000;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
            word_q  <= word_d;
            data_q  <= data_d;
            ready_q <= state_d == IDLE;
            valid_q <= state_d == RD_BURST;
            done_q  <= done_d;
            busy_q  <= state_d != IDLE;
        end
    end
endmodule

// File: tb/tb_mem_fill_responder.sv
// tb_mem_fill_responder: directed self-checking bench for mem_fill_responder
module tb_mem_fill_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_wr = 1'b0;
    logic [15:0] req_addr = 16'h0, req_data = 16'h0;
    logic        v4 = 1'b0, v2 = 1'b0, v15 = 1'b0;
    logic        r4, rv4, wd4, b4, r2, rv2, wd2, b2, r15, rv15, wd15, b15;
    logic [15:0] rd4, rd2, rd15;
    logic [2:0]  rw4, rw2, rw15;
    int          errs = 0;
    int          checks = 0;

    mem_fill_responder #(.LATENCY(4)) u4 (
        .clk(clk), .rst(rst), .req_valid(v4), .req_wr(req_wr), .req_addr(req_addr), .req_data(req_data),
        .req_ready(r4), .resp_valid(rv4), .resp_data(rd4), .resp_word(rw4), .wr_done(wd4), .busy(b4));
    mem_fill_responder #(.LATENCY(2)) u2 (
        .clk(clk), .rst(rst), .req_valid(v2), .req_wr(req_wr), .req_addr(req_addr), .req_data(req_data),
        .req_ready(r2), .resp_valid(rv2), .resp_data(rd2), .resp_word(rw2), .wr_done(wd2), .busy(b2));
    mem_fill_responder #(.LATENCY(15)) u15 (
        .clk(clk), .rst(rst), .req_valid(v15), .req_wr(req_wr), .req_addr(req_addr), .req_data(req_data),
        .req_ready(r15), .resp_valid(rv15), .resp_data(rd15), .resp_word(rw15), .wr_done(wd15), .busy(b15));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic wr, input logic [15:0] a, input logic [15:0] d);
        req_wr = wr;
        req_addr = a;
        req_data = d;
        v4 = 1'b1;
        tick();
        v4 = 1'b0;
    endtask

    task automatic wait_ready4();
        int k = 0;
        while (!r4 && k < 40) begin
            tick();
            k++;
        end
        checks++;
        if (r4 !== 1'b1) begin errs++; $display("FAIL wait_ready: req_ready=%b after %0d cycles, want 1", r4, k); end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++; if (r4 !== 1'b0) begin errs++; $display("FAIL rst_ready: got %b want 0", r4); end
        checks++; if (rv4 !== 1'b0) begin errs++; $display("FAIL rst_valid: got %b want 0", rv4); end
        checks++; if (rd4 !== 16'h0) begin errs++; $display("FAIL rst_data: got %h want 0000", rd4); end
        checks++; if (rw4 !== 3'd0) begin errs++; $display("FAIL rst_word: got %0d want 0", rw4); end
        checks++; if (wd4 !== 1'b0) begin errs++; $display("FAIL rst_wr_done: got %b want 0", wd4); end
        checks++; if (b4 !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b want 0", b4); end
        rst = 1'b0;
        tick();
        checks++; if ({r4, r2, r15} !== 3'b111) begin errs++; $display("FAIL post_rst_ready: got %b want 111", {r4, r2, r15}); end
        checks++; if (b4 !== 1'b0) begin errs++; $display("FAIL post_rst_busy: got %b want 0", b4); end
    endtask

    task automatic test_write();
        wait_ready4();
        present(1'b1, 16'h0006, 16'hBEEF);
        for (int k = 1; k <= 4; k++) begin
            checks++; if (r4 !== 1'b0) begin errs++; $display("FAIL wr_ready T+%0d: got %b want 0", k, r4); end
            checks++; if (wd4 !== (k == 4)) begin errs++; $display("FAIL wr_done T+%0d: got %b want %b", k, wd4, k == 4); end
            checks++; if (b4 !== 1'b1) begin errs++; $display("FAIL wr_busy T+%0d: got %b want 1", k, b4); end
            tick();
        end
        checks++; if (wd4 !== 1'b0) begin errs++; $display("FAIL wr_done T+5: got %b want 0", wd4); end
        checks++; if (r4 !== 1'b1) begin errs++; $display("FAIL wr_ready T+5: got %b want 1", r4); end
    endtask

    task automatic test_read();
        logic [15:0] ed;
        present(1'b0, 16'h000C, 16'h0);
        for (int k = 1; k <= 12; k++) begin
            ed = (k == 7) ? 16'hBEEF : 16'h0000;
            checks++; if (rv4 !== (k >= 4 && k <= 11)) begin errs++; $display("FAIL rd_valid T+%0d: got %b want %b", k, rv4, k >= 4 && k <= 11); end
            checks++; if (rd4 !== ed) begin errs++; $display("FAIL rd_data T+%0d: got %h want %h", k, rd4, ed); end
            if (k >= 4 && k <= 11) begin
                checks++; if (rw4 !== 3'(k - 4)) begin errs++; $display("FAIL rd_word T+%0d: got %0d want %0d", k, rw4, k - 4); end
            end
            if (k < 12) tick();
        end
        checks++; if (r4 !== 1'b1) begin errs++; $display("FAIL rd_ready T+12: got %b want 1", r4); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ed;
        wait_ready4();
        present(1'b1, 16'h0014, 16'h5A5A);
        wait_ready4();
        present(1'b1, 16'h0022, 16'h7777);
        wait_ready4();
        req_wr = 1'b0;
        v4 = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            req_addr = (k % 2 == 1) ? 16'h0022 : 16'h0010;
            if (k >= 1) begin
                checks++; if (r4 !== (k == 12)) begin errs++; $display("FAIL b2b_ready T+%0d: got %b want %b", k, r4, k == 12); end
            end
            if (k >= 4 && k <= 11) begin
                ed = (k == 6) ? 16'h5A5A : 16'h0000;
                checks++; if (rd4 !== ed || rv4 !== 1'b1) begin errs++; $display("FAIL b2b_beat1 T+%0d: got %b/%h want 1/%h", k, rv4, rd4, ed); end
            end
            tick();
        end
        v4 = 1'b0;
        for (int k = 13; k <= 24; k++) begin
            ed = (k == 18) ? 16'h5A5A : 16'h0000;
            checks++; if (rv4 !== (k >= 16 && k <= 23)) begin errs++; $display("FAIL b2b_valid2 T+%0d: got %b want %b", k, rv4, k >= 16 && k <= 23); end
            checks++; if (rd4 !== ed) begin errs++; $display("FAIL b2b_data2 T+%0d: got %h want %h", k, rd4, ed); end
            tick();
        end
    endtask

    task automatic test_alias();
        logic [15:0] exp [8];
        exp = '{16'h1234, 16'h0, 16'h0, 16'hBEEF, 16'h0, 16'h0, 16'h0, 16'h0};
        wait_ready4();
        present(1'b1, 16'h0800, 16'h1234);
        wait_ready4();
        present(1'b0, 16'h0000, 16'h0);
        for (int k = 1; k <= 3; k++) tick();
        for (int k = 4; k <= 11; k++) begin
            checks++; if (rv4 !== 1'b1 || rw4 !== 3'(k - 4) || rd4 !== exp[k-4]) begin
                errs++; $display("FAIL alias_beat%0d: got v=%b w=%0d d=%h want v=1 w=%0d d=%h", k - 4, rv4, rw4, rd4, k - 4, exp[k-4]);
            end
            tick();
        end
    endtask

    task automatic test_reset_abort();
        logic [15:0] exp [8];
        exp = '{16'h1234, 16'h0, 16'hCAFE, 16'hBEEF, 16'h0, 16'h0, 16'h0, 16'h0};
        wait_ready4();
        present(1'b1, 16'h0004, 16'hCAFE);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 3; k <= 8; k++) begin
            checks++; if (wd4 !== 1'b0) begin errs++; $display("FAIL wr_abort_done T+%0d: got %b want 0", k, wd4); end
            tick();
        end
        wait_ready4();
        present(1'b0, 16'h0000, 16'h0);
        for (int k = 1; k < 6; k++) tick();
        checks++; if (rv4 !== 1'b1 || rw4 !== 3'd2) begin errs++; $display("FAIL rd_abort_pre: got v=%b w=%0d want v=1 w=2", rv4, rw4); end
        rst = 1'b1;
        tick();
        checks++; if (rv4 !== 1'b0) begin errs++; $display("FAIL rd_abort_valid: got %b want 0", rv4); end
        checks++; if (rd4 !== 16'h0) begin errs++; $display("FAIL rd_abort_data: got %h want 0000", rd4); end
        checks++; if (rw4 !== 3'd0) begin errs++; $display("FAIL rd_abort_word: got %0d want 0", rw4); end
        checks++; if (r4 !== 1'b0 || b4 !== 1'b0) begin errs++; $display("FAIL rd_abort_rdy_busy: got %b%b want 00", r4, b4); end
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            checks++; if (rv4 !== 1'b0) begin errs++; $display("FAIL rd_abort_nobeat %0d: got %b want 0", k, rv4); end
        end
        wait_ready4();
        present(1'b0, 16'h0000, 16'h0);
        for (int k = 1; k <= 3; k++) tick();
        for (int k = 4; k <= 11; k++) begin
            checks++; if (rv4 !== 1'b1 || rd4 !== exp[k-4]) begin
                errs++; $display("FAIL reread_beat%0d: got v=%b d=%h want v=1 d=%h", k - 4, rv4, rd4, exp[k-4]);
            end
            tick();
        end
    endtask

    task automatic test_latency(input int lat);
        int k;
        for (int op = 0; op < 2; op++) begin
            req_wr = op[0];
            req_addr = 16'h0002;
            req_data = 16'h4321;
            k = 0;
            while (!((lat == 2) ? r2 : r15) && k < 40) begin tick(); k++; end
            v2 = lat == 2;
            v15 = lat == 15;
            tick();
            v2 = 1'b0;
            v15 = 1'b0;
            k = 1;
            while (!(op == 1 ? ((lat == 2) ? wd2 : wd15) : ((lat == 2) ? rv2 : rv15)) && k < 40) begin tick(); k++; end
            checks++; if (k !== lat) begin errs++; $display("FAIL latency%0d_%s: got %0d cycles want %0d", lat, op == 1 ? "wr" : "rd", k, lat); end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_alias();
        test_reset_abort();
        test_latency(2);
        test_latency(15);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
